// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA pattern generator: mode encodings, bar
// palette and the 640x480 timing constants also used by the timing generator.
package vga_pattern_gen_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_RAMP  = 2'd3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][11:0] BAR_COLORS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    return rgb_t'(BAR_COLORS[idx]);
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input mux.
module mux2 #(
  parameter int W = 1
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/vga_pos_tracker.sv
// Tracks active-area x/y position from the h/v enables, plus the bar and
// ramp sub-counters and the first-pixel-of-frame flag.
module vga_pos_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_STEP  = 40,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  input  logic       i_haddr_en,
  input  logic       i_vaddr_en,
  output logic       o_act,
  output logic       o_x_chk,
  output logic       o_y_chk,
  output logic [2:0] o_bar_idx,
  output logic [3:0] o_level,
  output logic       o_first_px
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);
  localparam int GW    = (GRAD_STEP > 1) ? $clog2(GRAD_STEP) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] bar_sub_q, bar_sub_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [GW-1:0] grad_sub_q, grad_sub_d;
  logic [3:0]    level_q, level_d;
  logic          h_prev_q, h_prev_d;
  logic          first_px_q, first_px_d;
  logic          act;

  assign act = i_haddr_en & i_vaddr_en;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    bar_sub_d  = bar_sub_q;
    bar_idx_d  = bar_idx_q;
    grad_sub_d = grad_sub_q;
    level_d    = level_q;
    h_prev_d   = h_prev_q;
    first_px_d = first_px_q;
    if (i_px_clk) begin
      h_prev_d = i_haddr_en;
      if (!i_haddr_en) begin
        x_d        = '0;
        bar_sub_d  = '0;
        bar_idx_d  = '0;
        grad_sub_d = '0;
        level_d    = '0;
      end else if (act) begin
        if (x_q != XW'(H_ACTIVE - 1)) x_d = x_q + 1'b1;
        if (bar_sub_q == BW'(BAR_W - 1)) begin
          bar_sub_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_sub_d = bar_sub_q + 1'b1;
        end
        if (grad_sub_q == GW'(GRAD_STEP - 1)) begin
          grad_sub_d = '0;
          if (level_q != 4'hF) level_d = level_q + 4'd1;
        end else begin
          grad_sub_d = grad_sub_q + 1'b1;
        end
      end
      // A line ends on the falling edge of haddr_en; vblank overrides it.
      if (!i_vaddr_en) begin
        y_d = '0;
      end else if (h_prev_q && !i_haddr_en && (y_q != YW'(V_ACTIVE - 1))) begin
        y_d = y_q + 1'b1;
      end
      if (!i_vaddr_en) first_px_d = 1'b1;
      else if (act)    first_px_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      bar_sub_q  <= '0;
      bar_idx_q  <= '0;
      grad_sub_q <= '0;
      level_q    <= '0;
      h_prev_q   <= 1'b0;
      first_px_q <= 1'b1;
    end else if (i_sclr) begin
      x_q        <= '0;
      y_q        <= '0;
      bar_sub_q  <= '0;
      bar_idx_q  <= '0;
      grad_sub_q <= '0;
      level_q    <= '0;
      h_prev_q   <= 1'b0;
      first_px_q <= 1'b1;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      bar_sub_q  <= bar_sub_d;
      bar_idx_q  <= bar_idx_d;
      grad_sub_q <= grad_sub_d;
      level_q    <= level_d;
      h_prev_q   <= h_prev_d;
      first_px_q <= first_px_d;
    end
  end

  assign o_act      = act;
  assign o_x_chk    = x_q[CHECK_LOG2];
  assign o_y_chk    = y_q[CHECK_LOG2];
  assign o_bar_idx  = bar_idx_q;
  assign o_level    = level_q;
  assign o_first_px = first_px_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator between the VGA timing counters and the DAC pins:
// solid, colour bars, checkerboard or grey ramp, registered with one px latency.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_STEP  = 40,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_sclr,
  input  logic        i_px_clk,
  input  logic        i_haddr_en,
  input  logic        i_vaddr_en,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_fg_color,
  output logic [3:0]  o_vga_red,
  output logic [3:0]  o_vga_green,
  output logic [3:0]  o_vga_blue,
  output logic        o_de,
  output logic        o_frame_start
);

  logic       act, x_chk, y_chk, first_px;
  logic [2:0] bar_idx;
  logic [3:0] level;

  vga_pos_tracker #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .CHECK_LOG2(CHECK_LOG2),
    .GRAD_STEP (GRAD_STEP),
    .XW        (XW),
    .YW        (YW)
  ) u_pos (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_sclr    (i_sclr),
    .i_px_clk  (i_px_clk),
    .i_haddr_en(i_haddr_en),
    .i_vaddr_en(i_vaddr_en),
    .o_act     (act),
    .o_x_chk   (x_chk),
    .o_y_chk   (y_chk),
    .o_bar_idx (bar_idx),
    .o_level   (level),
    .o_first_px(first_px)
  );

  logic [1:0] mode_q, mode_d;
  rgb_t       fg_q, fg_d;
  rgb_t       pat, rgb_sel;
  rgb_t       rgb_q, rgb_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;

  // Pattern settings only change during vblank so a frame is never torn.
  always_comb begin
    mode_d = mode_q;
    fg_d   = fg_q;
    if (i_px_clk && !i_vaddr_en) begin
      mode_d = i_mode;
      fg_d   = rgb_t'(i_fg_color);
    end
  end

  always_comb begin
    pat = fg_q;
    case (mode_q)
      MODE_SOLID: pat = fg_q;
      MODE_BARS:  pat = bar_color(bar_idx);
      MODE_CHECK: pat = (x_chk ^ y_chk) ? rgb_t'(12'h000) : fg_q;
      MODE_RAMP:  pat = '{r: level, g: level, b: level};
      default:    pat = fg_q;
    endcase
  end

  mux2 #(.W(12)) u_blank (
    .i_sel(act),
    .i_d0 (12'h000),
    .i_d1 (pat),
    .o_y  (rgb_sel)
  );

  always_comb begin
    rgb_d = rgb_q;
    de_d  = de_q;
    fs_d  = fs_q;
    if (i_px_clk) begin
      rgb_d = rgb_sel;
      de_d  = act;
      fs_d  = act & first_px;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_SOLID;
      fg_q   <= '0;
      rgb_q  <= '0;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else if (i_sclr) begin
      mode_q <= MODE_SOLID;
      fg_q   <= '0;
      rgb_q  <= '0;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      fg_q   <= fg_d;
      rgb_q  <= rgb_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
    end
  end

  assign o_vga_red     = rgb_q.r;
  assign o_vga_green   = rgb_q.g;
  assign o_vga_blue    = rgb_q.b;
  assign o_de          = de_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: one task per feature, hand-computed expectations.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, sclr, px, h, v;
  logic [1:0]  mode;
  logic [11:0] fg;
  logic [3:0]  r, g, b;
  logic        de, fs;
  logic [11:0] rgb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] lrgb [0:1023];
  logic        lde  [0:1023];
  logic        lfs  [0:1023];

  always #5 clk = ~clk;
  assign rgb = {r, g, b};

  vga_pattern_gen dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_sclr       (sclr),
    .i_px_clk     (px),
    .i_haddr_en   (h),
    .i_vaddr_en   (v),
    .i_mode       (mode),
    .i_fg_color   (fg),
    .o_vga_red    (r),
    .o_vga_green  (g),
    .o_vga_blue   (b),
    .o_de         (de),
    .o_frame_start(fs)
  );

  task automatic step(input logic hh, input logic vv);
    h = hh; v = vv;
    @(posedge clk); #1;
  endtask

  task automatic blank_frame(input logic [1:0] m, input logic [11:0] c);
    mode = m; fg = c;
    repeat (4) step(1'b0, 1'b0);
  endtask

  // Two hblank cycles then len active pixels; captures the output of each pixel.
  task automatic run_line(input int len);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < len; i++) begin
      step(1'b1, 1'b1);
      lrgb[i] = rgb; lde[i] = de; lfs[i] = fs;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sclr = 1'b0; px = 1'b1; h = 1'b0; v = 1'b0; mode = 2'd1; fg = 12'h000;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_tests++; if ({de, fs} !== 2'b00) begin n_fail++; $display("FAIL reset_de_fs: got %b want 00", {de, fs}); end
    rst_n = 1'b1;
    blank_frame(2'd1, 12'h000);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    for (int i = 0; i <= 100; i++) step(1'b1, 1'b1);
    n_tests++; if (rgb !== 12'hFF0 || de !== 1'b1) begin n_fail++; $display("FAIL reset_pre_px100: got %h/%b want ff0/1", rgb, de); end
    rst_n = 1'b0; #1;
    n_tests++; if (rgb !== 12'h000 || de !== 1'b0) begin n_fail++; $display("FAIL reset_async: got %h/%b want 000/0", rgb, de); end
    @(posedge clk); #1;
    h = 1'b0; v = 1'b0;
    rst_n = 1'b1;
    blank_frame(2'd1, 12'h000);
    run_line(100);
    n_tests++; if (lrgb[0] !== 12'hFFF || lrgb[79] !== 12'hFFF) begin n_fail++; $display("FAIL reset_restart_bar0: got %h,%h want fff,fff", lrgb[0], lrgb[79]); end
    n_tests++; if (lrgb[80] !== 12'hFF0) begin n_fail++; $display("FAIL reset_restart_px80: got %h want ff0", lrgb[80]); end
    n_tests++; if (lfs[0] !== 1'b1) begin n_fail++; $display("FAIL reset_restart_fs: got %b want 1", lfs[0]); end
  endtask

  task automatic test_solid;
    blank_frame(2'd0, 12'h0F0);
    run_line(8);
    n_tests++; if (lrgb[0][11:8] !== 4'h0 || lrgb[0][7:4] !== 4'hF || lrgb[0][3:0] !== 4'h0) begin n_fail++; $display("FAIL solid_px0: got %h want 0f0", lrgb[0]); end
    n_tests++; if (lde[0] !== 1'b1) begin n_fail++; $display("FAIL solid_de: got %b want 1", lde[0]); end
    n_tests++; if (lfs[0] !== 1'b1 || lfs[1] !== 1'b0) begin n_fail++; $display("FAIL solid_fs_once: got %b%b want 10", lfs[0], lfs[1]); end
    step(1'b0, 1'b1);
    n_tests++; if (rgb !== 12'h000 || de !== 1'b0) begin n_fail++; $display("FAIL solid_hblank: got %h/%b want 000/0", rgb, de); end
    step(1'b1, 1'b1);
    n_tests++; if (rgb !== 12'h0F0 || fs !== 1'b0) begin n_fail++; $display("FAIL solid_line1: got %h/%b want 0f0/0", rgb, fs); end
    px = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    n_tests++; if (rgb !== 12'h0F0 || de !== 1'b1) begin n_fail++; $display("FAIL solid_pxclk_hold: got %h/%b want 0f0/1", rgb, de); end
    px = 1'b1;
  endtask

  task automatic test_bars;
    int          idx [11] = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 649};
    logic [11:0] exp [11] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F,
                              12'hF00, 12'h00F, 12'h000, 12'h000, 12'h000};
    blank_frame(2'd1, 12'h000);
    run_line(650);
    for (int k = 0; k < 11; k++) begin
      n_tests++;
      if (lrgb[idx[k]] !== exp[k]) begin n_fail++; $display("FAIL bars_px%0d: got %h want %h", idx[k], lrgb[idx[k]], exp[k]); end
    end
    n_tests++; if (lde[649] !== 1'b1) begin n_fail++; $display("FAIL bars_ext_de: got %b want 1", lde[649]); end
  endtask

  task automatic test_checker;
    blank_frame(2'd2, 12'hF00);
    run_line(64);
    n_tests++; if (lrgb[31] !== 12'hF00) begin n_fail++; $display("FAIL chk_x31_y0: got %h want f00", lrgb[31]); end
    n_tests++; if (lrgb[32] !== 12'h000) begin n_fail++; $display("FAIL chk_x32_y0: got %h want 000", lrgb[32]); end
    repeat (31) run_line(2);
    run_line(64);
    n_tests++; if (lrgb[0] !== 12'h000) begin n_fail++; $display("FAIL chk_x0_y32: got %h want 000", lrgb[0]); end
    n_tests++; if (lrgb[32] !== 12'hF00) begin n_fail++; $display("FAIL chk_x32_y32: got %h want f00", lrgb[32]); end
  endtask

  task automatic test_ramp;
    int          idx [7] = '{0, 39, 40, 80, 599, 600, 639};
    logic [11:0] exp [7] = '{12'h000, 12'h000, 12'h111, 12'h222, 12'hEEE, 12'hFFF, 12'hFFF};
    blank_frame(2'd3, 12'h000);
    run_line(640);
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (lrgb[idx[k]] !== exp[k]) begin n_fail++; $display("FAIL ramp_px%0d: got %h want %h", idx[k], lrgb[idx[k]], exp[k]); end
    end
  endtask

  task automatic test_mode_change;
    blank_frame(2'd0, 12'h0F0);
    repeat (100) run_line(4);
    mode = 2'd1;
    run_line(4);
    n_tests++; if (lrgb[0] !== 12'h0F0) begin n_fail++; $display("FAIL modechg_line100: got %h want 0f0", lrgb[0]); end
    run_line(4);
    n_tests++; if (lrgb[3] !== 12'h0F0) begin n_fail++; $display("FAIL modechg_line101: got %h want 0f0", lrgb[3]); end
    blank_frame(2'd1, 12'h0F0);
    run_line(4);
    n_tests++; if (lrgb[0] !== 12'hFFF) begin n_fail++; $display("FAIL modechg_next_frame: got %h want fff", lrgb[0]); end
  endtask

  task automatic test_sclr;
    blank_frame(2'd1, 12'h000);
    run_line(10);
    n_tests++; if (lrgb[9] !== 12'hFFF) begin n_fail++; $display("FAIL sclr_pre: got %h want fff", lrgb[9]); end
    sclr = 1'b1;
    step(1'b1, 1'b1);
    sclr = 1'b0;
    n_tests++; if (rgb !== 12'h000 || de !== 1'b0) begin n_fail++; $display("FAIL sclr_out: got %h/%b want 000/0", rgb, de); end
    step(1'b1, 1'b1);
    n_tests++; if (rgb !== 12'h000 || de !== 1'b1 || fs !== 1'b1) begin n_fail++; $display("FAIL sclr_after: got %h/%b/%b want 000/1/1", rgb, de, fs); end
  endtask

  initial begin
    rst_n = 1'b0; sclr = 1'b0; px = 1'b1; h = 1'b0; v = 1'b0; mode = 2'd0; fg = 12'h000;
    test_reset;
    test_solid;
    test_bars;
    test_checker;
    test_ramp;
    test_mode_change;
    test_sclr;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
